// File: rtl/dsd_tx_mc.sv
// dsd_tx_mc: multi-channel native-DSD serialiser; one bclk domain, dclk derived by an internal divider.
// Optional macro DSD_TX_MC_BITREV_EN adds the lsb_first input for per-channel LSB-first transmission.
module dsd_tx_mc #(
  parameter int         DW         = 16,
  parameter int         CH         = 2,
  parameter int         DIV_LOG2   = 2,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_PAT   = 8'h69
) (
  input  logic                            bclk,
  input  logic                            rst,
  input  logic                            enable,
`ifdef DSD_TX_MC_BITREV_EN
  input  logic                            lsb_first,
`endif
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [CH*DW-1:0]                s_data,
  output logic                            dclk,
  output logic [CH-1:0]                   dsd_o,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DW);
  localparam logic [DIV_LOG2-1:0] SHIFT_PHASE = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);
  localparam logic [BW-1:0]       LAST_BIT    = BW'(DW - 1);
  localparam logic [LW-1:0]       FULL_LEVEL  = LW'(FIFO_DEPTH);
  localparam logic [DW-1:0]       IDLE_WORD   = {(DW / 8){IDLE_PAT}};

  logic [DIV_LOG2-1:0]   dcnt_q, dcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [CH-1:0][DW-1:0] shiftReg_q, shiftReg_d;
  logic [CH*DW-1:0]      fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  underrun_q, underrun_d;

  logic                  shiftEn, boundary, fifoEmpty, push, pop;
  logic [CH*DW-1:0]      headWord;
  logic [CH-1:0][DW-1:0] loadWord;

  assign s_ready    = (level_q != FULL_LEVEL);
  assign dclk       = ~dcnt_q[DIV_LOG2-1];
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

  always_comb begin
    for (int c = 0; c < CH; c++) dsd_o[c] = shiftReg_q[c][DW-1];
  end

  // Shifts happen on the bclk edge where dclk falls, so data is stable at the DAC's rising edge.
  always_comb begin
    shiftEn   = (dcnt_q == SHIFT_PHASE);
    boundary  = shiftEn && (bcnt_q == LAST_BIT);
    fifoEmpty = (level_q == '0);
    push      = s_valid && s_ready;
    pop       = boundary && enable && !fifoEmpty;
    headWord  = fifoMem_q[rdPtr_q];

    for (int c = 0; c < CH; c++) begin
      loadWord[c] = headWord[c*DW +: DW];
`ifdef DSD_TX_MC_BITREV_EN
      if (lsb_first) begin
        for (int b = 0; b < DW; b++) loadWord[c][b] = headWord[c*DW + DW - 1 - b];
      end
`endif
    end

    dcnt_d     = dcnt_q + 1'b1;
    bcnt_d     = bcnt_q;
    shiftReg_d = shiftReg_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
    underrun_d = boundary && enable && fifoEmpty;

    if (shiftEn) begin
      if (boundary) begin
        bcnt_d = '0;
        if (pop) begin
          shiftReg_d = loadWord;
          rdPtr_d    = rdPtr_q + 1'b1;
        end else begin
          shiftReg_d = {CH{IDLE_WORD}};
        end
      end else begin
        bcnt_d = bcnt_q + 1'b1;
        for (int c = 0; c < CH; c++) shiftReg_d[c] = {shiftReg_q[c][DW-2:0], 1'b0};
      end
    end

    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge bclk) begin
    if (push) fifoMem_q[wrPtr_q] <= s_data;
  end

  // Reset starts one bit before a word boundary, so the first dclk fall reloads the idle word.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      dcnt_q     <= '0;
      bcnt_q     <= LAST_BIT;
      shiftReg_q <= {CH{IDLE_WORD}};
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      dcnt_q     <= dcnt_d;
      bcnt_q     <= bcnt_d;
      shiftReg_q <= shiftReg_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
    end
  end
endmodule

// File: tb/tb_dsd_tx_mc.sv
// tb_dsd_tx_mc: self-checking bench for dsd_tx_mc against a word/bit-level stream model.
// Covers the lsb_first input when DSD_TX_MC_BITREV_EN is defined.
module tb_dsd_tx_mc;
  localparam int DW         = 16;
  localparam int CH         = 2;
  localparam int DIV_LOG2   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int P          = 1 << DIV_LOG2;
  localparam int HALF       = P / 2;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);
  localparam int OW         = 1 + CH + 1 + LW + 1;
  localparam logic [DW-1:0] IDLE_WORD = 16'h6969;

  logic             bclk    = 1'b0;
  logic             rst     = 1'b0;
  logic             enable  = 1'b0;
  logic             s_valid = 1'b0;
  logic [CH*DW-1:0] s_data  = '0;
`ifdef DSD_TX_MC_BITREV_EN
  logic             lsb_first = 1'b0;
`endif
  logic             s_ready;
  logic             dclk;
  logic [CH-1:0]    dsd_o;
  logic             underrun;
  logic [LW-1:0]    fifo_level;
  logic [OW-1:0]    obsVec;

  int checks   = 0;
  int failures = 0;

  dsd_tx_mc #(.DW(DW), .CH(CH), .DIV_LOG2(DIV_LOG2), .FIFO_DEPTH(FIFO_DEPTH), .IDLE_PAT(8'h69)) dut (
    .bclk       (bclk),
    .rst        (rst),
    .enable     (enable),
`ifdef DSD_TX_MC_BITREV_EN
    .lsb_first  (lsb_first),
`endif
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .dclk       (dclk),
    .dsd_o      (dsd_o),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 bclk = ~bclk;

  assign obsVec = {dclk, dsd_o, underrun, fifo_level, s_ready};

  // Stream model: counts bclk edges, derives dclk falls and word boundaries arithmetically,
  // and keeps the accepted words in a queue.
  logic [CH*DW-1:0] modelQ [$];
  logic [CH*DW-1:0] curWord;
  logic [CH*DW-1:0] loaded;
  logic [DW-1:0]    chanW;
  int unsigned      edgeN;
  int unsigned      shiftN;
  int               bitPos;
  int               sizeBefore;
  logic             expUnder;
  logic             lastLoadData;

  always @(posedge bclk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      curWord      = {CH{IDLE_WORD}};
      edgeN        = 0;
      shiftN       = 0;
      bitPos       = 0;
      expUnder     = 1'b0;
      lastLoadData = 1'b0;
    end else begin
      sizeBefore = modelQ.size();
      edgeN++;
      expUnder = 1'b0;
      if ((edgeN % P) == HALF) begin
        if ((shiftN % DW) == 0) begin
          bitPos = 0;
          if (enable && sizeBefore > 0) begin
            loaded = modelQ.pop_front();
`ifdef DSD_TX_MC_BITREV_EN
            if (lsb_first) begin
              for (int c = 0; c < CH; c++) begin
                chanW = loaded[c*DW +: DW];
                loaded[c*DW +: DW] = {<<{chanW}};
              end
            end
`endif
            curWord      = loaded;
            lastLoadData = 1'b1;
          end else begin
            curWord      = {CH{IDLE_WORD}};
            lastLoadData = 1'b0;
            expUnder     = enable;
          end
        end else begin
          bitPos++;
        end
        shiftN++;
      end
      if (s_valid && sizeBefore < FIFO_DEPTH) modelQ.push_back(s_data);
    end
  end

  function automatic logic [OW-1:0] expVec();
    logic [CH-1:0] d;
    logic          dc;
    for (int c = 0; c < CH; c++) d[c] = curWord[c*DW + DW - 1 - bitPos];
    dc = ((edgeN % P) < HALF);
    return {dc, d, expUnder, LW'(modelQ.size()), (modelQ.size() < FIFO_DEPTH)};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obsVec !== {1'b1, {CH{1'b0}}, 1'b0, {LW{1'b0}}, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_values got=%b want=%b", obsVec, {1'b1, {CH{1'b0}}, 1'b0, {LW{1'b0}}, 1'b1});
    end
    @(negedge bclk);
    @(negedge bclk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL idle cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_single_word();
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = {16'hA5F0, 16'h1234};
    for (int i = 0; i < 160; i++) begin
      @(negedge bclk);
      s_valid = 1'b0;
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL single_word cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int  sent     = 0;
    int  maxLevel = 0;
    bit  took;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = (CH*DW)'({$urandom, $urandom});
    took    = s_ready;
    for (int i = 0; i < 300 && sent < 8; i++) begin
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
      if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
      if (took) begin
        sent++;
        s_data = (CH*DW)'({$urandom, $urandom});
      end
      if (sent == 8) s_valid = 1'b0;
      took = s_valid && s_ready;
    end
    checks++;
    if (sent != 8) begin
      failures++;
      $display("[TB] FAIL back_to_back_accept got=%0d want=8", sent);
    end
    checks++;
    if (maxLevel != FIFO_DEPTH) begin
      failures++;
      $display("[TB] FAIL back_to_back_maxlevel got=%0d want=%0d", maxLevel, FIFO_DEPTH);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL drain cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_enable_drop();
    int waited = 0;
    enable  = 1'b1;
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = (CH*DW)'({$urandom, $urandom});
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL enable_drop_fill k=%0d got=%b want=%b", k, obsVec, expVec());
      end
    end
    s_valid = 1'b0;
    while (waited < 400 && !(lastLoadData && bitPos == 5)) begin
      @(negedge bclk);
      waited++;
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL enable_drop_wait cyc=%0d got=%b want=%b", waited, obsVec, expVec());
      end
    end
    checks++;
    if (waited >= 400) begin
      failures++;
      $display("[TB] FAIL enable_drop_timeout got=%0d want<400", waited);
    end
    enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL enable_drop_idle cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
    end
    checks++;
    if (fifo_level !== LW'(3)) begin
      failures++;
      $display("[TB] FAIL enable_drop_level got=%0d want=3", fifo_level);
    end
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL reenable cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      s_valid = ($urandom_range(0, 3) == 0);
      s_data  = (CH*DW)'({$urandom, $urandom});
    end
  endtask

  task automatic test_mid_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 37; i++) begin
      s_data = (CH*DW)'({$urandom, $urandom});
      @(negedge bclk);
    end
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obsVec !== {1'b1, {CH{1'b0}}, 1'b0, {LW{1'b0}}, 1'b1}) begin
      failures++;
      $display("[TB] FAIL mid_reset got=%b want=%b", obsVec, {1'b1, {CH{1'b0}}, 1'b0, {LW{1'b0}}, 1'b1});
    end
    @(negedge bclk);
    rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge bclk);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL after_reset cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
    end
  endtask

`ifdef DSD_TX_MC_BITREV_EN
  task automatic test_bitrev();
    lsb_first = 1'b1;
    enable    = 1'b1;
    s_valid   = 1'b1;
    s_data    = {16'h8001, 16'h0003};
    for (int i = 0; i < 160; i++) begin
      @(negedge bclk);
      s_valid = 1'b0;
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL bitrev cyc=%0d got=%b want=%b", i, obsVec, expVec());
      end
    end
    lsb_first = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_enable_drop();
    test_random();
    test_mid_reset();
`ifdef DSD_TX_MC_BITREV_EN
    test_bitrev();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsd_tx_mc.md
Name: dsd_tx_mc

Overview:
Parametrised multi-channel native-DSD serialiser; successor to the 2-channel DSD transmitter.
Runs entirely in the bclk domain and derives dclk with an internal divider, so no clock-domain-crossing pulse synchroniser is needed.
Accepts CH-channel words through a valid/ready handshake into a small FIFO and shifts them out MSB-first, one bit per dclk.
Emits the DSD idle pattern on underrun or when disabled, and flags each underrun.

Parameters:
DW, 16, bits per channel word; must be a multiple of 8.
CH, 2, number of DSD channels.
DIV_LOG2, 2, dclk = bclk / 2^DIV_LOG2; must be >= 1.
FIFO_DEPTH, 4, input FIFO depth in CH*DW-bit entries; power of 2, >= 2.
IDLE_PAT, 8'h69, DSD silence byte, replicated DW/8 times per word.

Ports:
bclk  in  1  bit clock; sole clock.
rst  in  1  asynchronous, active-high reset.
enable  in  1  1 = stream FIFO data; 0 = idle pattern only.
s_valid  in  1  input word valid.
s_ready  out  1  FIFO not full.
s_data  in  CH*DW  channel c occupies bits [c*DW +: DW].
dclk  out  1  DSD bit clock to the DAC; the DAC samples on the rising edge.
dsd_o  out  CH  serial data, one bit per channel.
underrun  out  1  one-bclk pulse per idle-pattern word loaded while enable=1.
fifo_level  out  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.

Behaviour:
- Reset values: dcnt=0; dclk=1; every shift register = IDLE_PAT pattern, so dsd_o = IDLE_PAT[7] on all channels; bcnt=DW-1; FIFO empty; fifo_level=0; s_ready=1; underrun=0.
- Divider: dcnt (DIV_LOG2 bits) increments every bclk and wraps. Internal dclk_i = dcnt[MSB]; dclk = ~dclk_i.
- shift_en is asserted in the cycle where dcnt == 2^(DIV_LOG2-1)-1, i.e. the edge on which dclk falls. All shifts and loads occur only on shift_en, so dsd_o changes on the dclk falling edge and is stable at the rising edge.
- Bit counter: bcnt counts 0..DW-1 on shift_en. Word boundary = shift_en && bcnt==DW-1; at the boundary bcnt wraps to 0.
- At a word boundary: if enable=1 and the FIFO is not empty, pop one entry and load every channel's shift register. Otherwise load IDLE_PAT replicated DW/8 times.
- underrun pulses for exactly one bclk at the boundary when enable=1 and the FIFO is empty.
- Not at a word boundary: every channel shifts left by 1; dsd_o[c] = shift register c, bit DW-1.
- enable falling mid-word: the current word completes, then idle words are loaded. FIFO contents are retained, not flushed.
- enable rising: streaming starts at the next word boundary; no partial words are ever emitted.
- FIFO: push when s_valid && s_ready. s_ready = (fifo_level != FIFO_DEPTH), combinational from registered state.
  - Push and pop in the same cycle: level unchanged, both take effect.
  - Pop when empty: the idle word is loaded and the level stays 0.
  - Push when full: impossible because s_ready=0; s_data is ignored.
- Latency: with an empty FIFO, a word accepted at least one bclk before a boundary appears on dsd_o, MSB first, from that boundary on.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); in-flight and FIFO data are lost.

Optional Feature:
Macro DSD_TX_MC_BITREV_EN adds input port lsb_first (1 bit), sampled at each word boundary.
- lsb_first=1: the loaded FIFO word is bit-reversed per channel before loading, so each channel transmits LSB-first.
- lsb_first=0, or macro absent: transmission is MSB-first.
- The idle pattern is never reversed.
- Without the macro the port does not exist.

Test Plan:
- Reset, then idle with enable=0, DW=16, CH=2, DIV_LOG2=2: dclk period = 4 bclk; each dsd_o channel repeats 0110_1001 per dclk bit; underrun stays 0; s_ready=1.
- enable=1, push {16'hA5F0, 16'h1234} (ch1, ch0) once: from the next boundary, ch1 emits A5F0 and ch0 emits 1234, MSB-first, each bit held 4 bclk. Then idle words follow, with one underrun pulse per idle word.
- Continuous push of 8 words with enable=1 and FIFO_DEPTH=4: fifo_level saturates at 4 and s_ready drops; no word is lost or duplicated; no underrun until the FIFO drains.
- Deassert enable at bit 5 of a word while the FIFO holds 3 entries: that word completes all 16 bits, idle follows, fifo_level stays 3, underrun=0. On re-enable, the 3 words stream in order.
- Assert rst for 1 bclk at mid-word: dclk=1, dsd_o=0, fifo_level=0, underrun=0 immediately. On release, the first dclk fall occurs 2 bclk later.
- With DSD_TX_MC_BITREV_EN defined and lsb_first=1, push 16'h8001 / 16'h0003: ch1 emits 8001 reversed (= 8001), ch0 emits C000 MSB-first.
